// File: rtl/ext_load_sequencer.sv
// Host-side sequencer for top_control_8's external port: streams IRAM and DRAM images in,
// runs the cores, then reads back the final-matrix DRAM window onto an output stream.
module ext_load_sequencer #(
    parameter int NUM_CORES  = 8,
    parameter int ADDR_W     = 9,
    parameter int WR_PULSE   = 4,
    parameter int READ_LAT   = 5,
    parameter int RUN_CYCLES = 120000
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 go,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [15:0]          in_data,
    input  logic                 run_done,
    input  logic [15:0]          dram_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [15:0]          out_data,
    output logic                 start,
    output logic                 start_2,
    output logic                 start_3,
    output logic                 start_4,
    output logic [ADDR_W-1:0]    addr_ext,
    output logic [NUM_CORES-1:0] iram_write_ext,
    output logic                 dram_write_ext,
    output logic                 read_en_ext,
    output logic [15:0]          Data_in_ins,
    output logic [15:0]          Data_in_dram,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    localparam int SEG_W   = $clog2(NUM_CORES + 1);
    localparam int CNT_MAX = (RUN_CYCLES > WR_PULSE)
                           ? ((RUN_CYCLES > READ_LAT) ? RUN_CYCLES : READ_LAT)
                           : ((WR_PULSE > READ_LAT) ? WR_PULSE : READ_LAT);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    // Segment indices 0..NUM_CORES-1 are IRAMs; NUM_CORES is the DRAM segment.
    localparam logic [SEG_W-1:0] DRAM_SEG  = SEG_W'(NUM_CORES);
    localparam logic [SEG_W-1:0] LAST_CORE = SEG_W'(NUM_CORES - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_LEN,
        S_WSETUP,
        S_WE,
        S_HOLD,
        S_GAP_LOAD,
        S_PARAM,
        S_GAP_PARAM,
        S_RUN,
        S_GAP_RUN,
        S_RSETUP,
        S_RWAIT,
        S_ROUT,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [SEG_W-1:0]  seg_q, seg_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       ins_q, ins_d;
    logic [15:0]       dram_q, dram_d;
    logic [15:0]       out_data_q, out_data_d;
    logic [ADDR_W-1:0] fs_q, fs_d;
    logic [ADDR_W-1:0] fe_q, fe_d;
    logic              pidx_q, pidx_d;
    logic              err_q, err_d;

    logic              accept;
    logic              seg_end;
    logic              len_too_big;
    logic              is_iram;
    logic              load_phase;
    logic [ADDR_W-1:0] addr_inc;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            seg_q      <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            addr_q     <= '0;
            ins_q      <= '0;
            dram_q     <= '0;
            out_data_q <= '0;
            fs_q       <= '0;
            fe_q       <= '0;
            pidx_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            seg_q      <= seg_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            ins_q      <= ins_d;
            dram_q     <= dram_d;
            out_data_q <= out_data_d;
            fs_q       <= fs_d;
            fe_q       <= fe_d;
            pidx_q     <= pidx_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        seg_d       = seg_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        ins_d       = ins_q;
        dram_d      = dram_q;
        out_data_d  = out_data_q;
        fs_d        = fs_q;
        fe_d        = fe_q;
        pidx_d      = pidx_q;
        err_d       = err_q;
        seg_end     = 1'b0;

        is_iram     = (seg_q != DRAM_SEG);
        load_phase  = (state_q == S_LEN) || (state_q == S_WSETUP) ||
                      (state_q == S_WE)  || (state_q == S_HOLD);
        in_ready    = (state_q == S_LEN) || (state_q == S_WSETUP) || (state_q == S_PARAM);
        accept      = in_valid && in_ready;
        len_too_big = |in_data[15:ADDR_W];
        addr_inc    = addr_q + ADDR_W'(1);

        start          = (state_q == S_RUN);
        start_2        = load_phase && is_iram;
        start_3        = load_phase && !is_iram;
        start_4        = (state_q == S_RSETUP) || (state_q == S_RWAIT) || (state_q == S_ROUT);
        iram_write_ext = (state_q == S_WE && is_iram) ? (NUM_CORES'(1) << seg_q) : '0;
        dram_write_ext = (state_q == S_WE) && !is_iram;
        read_en_ext    = (state_q == S_RWAIT);
        out_valid      = (state_q == S_ROUT);
        busy           = (state_q != S_IDLE) && (state_q != S_DONE);
        done           = (state_q == S_DONE);
        addr_ext       = addr_q;
        Data_in_ins    = ins_q;
        Data_in_dram   = dram_q;
        out_data       = out_data_q;
        err            = err_q;

        case (state_q)
            S_IDLE: begin
                if (go) begin
                    state_d = S_LEN;
                    seg_d   = '0;
                    addr_d  = ADDR_W'(1);
                    err_d   = 1'b0;
                end
            end
            S_LEN: begin
                if (accept) begin
                    if (len_too_big) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else if (in_data == 16'd0) begin
                        seg_end = 1'b1;
                    end else begin
                        len_d   = in_data[ADDR_W-1:0];
                        state_d = S_WSETUP;
                    end
                end
            end
            S_WSETUP: begin
                if (accept) begin
                    if (is_iram) ins_d = in_data;
                    else         dram_d = in_data;
                    cnt_d   = '0;
                    state_d = S_WE;
                end
            end
            S_WE: begin
                if (cnt_q == CNT_W'(WR_PULSE - 1)) state_d = S_HOLD;
                else                                cnt_d   = cnt_q + CNT_W'(1);
            end
            S_HOLD: begin
                addr_d = addr_inc;
                len_d  = len_q - ADDR_W'(1);
                if (len_q == ADDR_W'(1)) seg_end = 1'b1;
                else                     state_d = S_WSETUP;
            end
            S_GAP_LOAD: begin
                addr_d  = ADDR_W'(1);
                state_d = S_LEN;
            end
            S_PARAM: begin
                if (accept) begin
                    if (!pidx_q) begin
                        fs_d   = in_data[ADDR_W-1:0];
                        pidx_d = 1'b1;
                    end else begin
                        fe_d    = in_data[ADDR_W-1:0];
                        state_d = S_GAP_PARAM;
                    end
                end
            end
            S_GAP_PARAM: begin
                cnt_d   = '0;
                state_d = S_RUN;
            end
            S_RUN: begin
                if (run_done || cnt_q == CNT_W'(RUN_CYCLES - 1)) state_d = S_GAP_RUN;
                else                                              cnt_d   = cnt_q + CNT_W'(1);
            end
            S_GAP_RUN: begin
                addr_d  = fs_q;
                state_d = (fs_q < fe_q) ? S_RSETUP : S_DONE;
            end
            S_RSETUP: begin
                cnt_d   = '0;
                state_d = S_RWAIT;
            end
            S_RWAIT: begin
                if (cnt_q == CNT_W'(READ_LAT - 1)) begin
                    out_data_d = dram_in;
                    state_d    = S_ROUT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_ROUT: begin
                if (out_ready) begin
                    addr_d  = addr_inc;
                    state_d = (addr_inc < fe_q) ? S_RSETUP : S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A finished segment advances to the next core, the gap before DRAM, or the parameters.
        if (seg_end) begin
            if (seg_q == DRAM_SEG) begin
                pidx_d  = 1'b0;
                state_d = S_PARAM;
            end else if (seg_q == LAST_CORE) begin
                seg_d   = seg_q + SEG_W'(1);
                state_d = S_GAP_LOAD;
            end else begin
                seg_d   = seg_q + SEG_W'(1);
                addr_d  = ADDR_W'(1);
                state_d = S_LEN;
            end
        end

        // Every data-path register is already back at zero while done is high.
        if (state_d == S_DONE) begin
            seg_d      = '0;
            len_d      = '0;
            cnt_d      = '0;
            addr_d     = '0;
            ins_d      = '0;
            dram_d     = '0;
            out_data_d = '0;
            fs_d       = '0;
            fe_d       = '0;
            pidx_d     = 1'b0;
        end
    end

endmodule

// File: tb/tb_ext_load_sequencer.sv
// Directed self-checking bench for ext_load_sequencer with two cores and a short run window.
module tb_ext_load_sequencer;

    localparam int NC  = 2;
    localparam int AW  = 9;
    localparam int WP  = 4;
    localparam int RL  = 5;
    localparam int RC  = 40;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          go;
    logic          in_valid;
    logic          in_ready;
    logic [15:0]   in_data;
    logic          run_done;
    logic [15:0]   dram_in;
    logic          out_valid;
    logic          out_ready;
    logic [15:0]   out_data;
    logic          start, start_2, start_3, start_4;
    logic [AW-1:0] addr_ext;
    logic [NC-1:0] iram_write_ext;
    logic          dram_write_ext;
    logic          read_en_ext;
    logic [15:0]   Data_in_ins;
    logic [15:0]   Data_in_dram;
    logic          busy;
    logic          done;
    logic          err;

    int checks   = 0;
    int failures = 0;

    logic [15:0] stim_q[$];
    logic [2:0]  rec_we[$];
    logic [8:0]  rec_addr[$];
    logic [15:0] rec_data[$];
    int          rec_width[$];
    logic [15:0] out_words[$];
    int          start_cycles, done_count, overlap_viol, stall_viol, unstable_viol, pulse_len;
    logic [2:0]  cur_we;
    logic [8:0]  cur_addr;
    logic [15:0] cur_data;
    logic        mon_clear = 1'b0;
    logic [15:0] dram_mem [0:511];
    int          rd_cnt = 0;

    logic [2:0]  exp_we   [5] = '{3'b001, 3'b001, 3'b001, 3'b100, 3'b100};
    logic [8:0]  exp_addr [5] = '{9'd1, 9'd2, 9'd3, 9'd1, 9'd2};
    logic [15:0] exp_data [5] = '{16'd10, 16'd20, 16'd30, 16'd7, 16'd8};

    logic [67:0] quiet_outs;
    assign quiet_outs = {in_ready, out_valid, out_data, start, start_2, start_3, start_4,
                         addr_ext, iram_write_ext, dram_write_ext, read_en_ext,
                         Data_in_ins, Data_in_dram, busy};

    ext_load_sequencer #(
        .NUM_CORES (NC),
        .ADDR_W    (AW),
        .WR_PULSE  (WP),
        .READ_LAT  (RL),
        .RUN_CYCLES(RC)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .go            (go),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .run_done      (run_done),
        .dram_in       (dram_in),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .start         (start),
        .start_2       (start_2),
        .start_3       (start_3),
        .start_4       (start_4),
        .addr_ext      (addr_ext),
        .iram_write_ext(iram_write_ext),
        .dram_write_ext(dram_write_ext),
        .read_en_ext   (read_en_ext),
        .Data_in_ins   (Data_in_ins),
        .Data_in_dram  (Data_in_dram),
        .busy          (busy),
        .done          (done),
        .err           (err)
    );

    always #5 clock = ~clock;

    // DRAM model: data only appears once read_en_ext has been held for the full latency.
    always @(posedge clock) rd_cnt <= read_en_ext ? rd_cnt + 1 : 0;
    assign dram_in = (read_en_ext && rd_cnt >= RL - 1) ? dram_mem[addr_ext] : 16'hDEAD;

    // Observes write pulses, mode strobes and readout handshakes away from the active edge.
    always @(negedge clock) begin
        if (mon_clear) begin
            rec_we.delete();
            rec_addr.delete();
            rec_data.delete();
            rec_width.delete();
            out_words.delete();
            start_cycles  = 0;
            done_count    = 0;
            overlap_viol  = 0;
            stall_viol    = 0;
            unstable_viol = 0;
            pulse_len     = 0;
        end else begin
            if (start) start_cycles++;
            if (done) done_count++;
            if (start_2 && start_3) overlap_viol++;
            if (in_ready && (|iram_write_ext || dram_write_ext)) stall_viol++;
            if (out_valid && out_ready) out_words.push_back(out_data);
            if (dram_write_ext) dram_mem[addr_ext] = Data_in_dram;
            if (|iram_write_ext || dram_write_ext) begin
                if (pulse_len == 0) begin
                    cur_we   = {dram_write_ext, iram_write_ext};
                    cur_addr = addr_ext;
                    cur_data = dram_write_ext ? Data_in_dram : Data_in_ins;
                end else if ({dram_write_ext, iram_write_ext} !== cur_we || addr_ext !== cur_addr ||
                             (dram_write_ext ? Data_in_dram : Data_in_ins) !== cur_data) begin
                    unstable_viol++;
                end
                pulse_len++;
            end else if (pulse_len != 0) begin
                rec_we.push_back(cur_we);
                rec_addr.push_back(cur_addr);
                rec_data.push_back(cur_data);
                rec_width.push_back(pulse_len);
                pulse_len = 0;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clearMonitor();
        mon_clear = 1'b1;
        @(negedge clock);
        #1;
        mon_clear = 1'b0;
    endtask

    task automatic startSession();
        go = 1'b1;
        tick();
        go = 1'b0;
    endtask

    task automatic loadFullStream();
        stim_q = {16'd3, 16'd10, 16'd20, 16'd30, 16'd0, 16'd2, 16'd7, 16'd8, 16'd1, 16'd3};
    endtask

    // Feeds stim_q into the stream port; toggle drops in_valid every other cycle.
    task automatic applyStimulus(input bit toggle, input int max_cycles);
        int  idx   = 0;
        int  cyc   = 0;
        bit  phase = 1'b1;
        bit  took;
        while (idx < stim_q.size() && cyc < max_cycles) begin
            in_data  = stim_q[idx];
            in_valid = toggle ? phase : 1'b1;
            phase    = !phase;
            @(negedge clock);
            took = in_valid && in_ready;
            tick();
            if (took) idx++;
            cyc++;
        end
        in_valid = 1'b0;
        checkOutput("stream_consumed", idx, stim_q.size());
    endtask

    task automatic waitDone(input string pfx, input int bound);
        bit seen = 1'b0;
        for (int i = 0; i < bound && !seen; i++) begin
            @(negedge clock);
            if (done) seen = 1'b1;
        end
        checkOutput({pfx, "_done_seen"}, seen, 1);
    endtask

    task automatic verifyWrites(input string pfx);
        checkOutput({pfx, "_nwrites"}, rec_we.size(), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < rec_we.size()) begin
                checkOutput($sformatf("%s_we%0d", pfx, i), rec_we[i], exp_we[i]);
                checkOutput($sformatf("%s_addr%0d", pfx, i), rec_addr[i], exp_addr[i]);
                checkOutput($sformatf("%s_data%0d", pfx, i), rec_data[i], exp_data[i]);
                checkOutput($sformatf("%s_width%0d", pfx, i), rec_width[i], WP);
            end
        end
        checkOutput({pfx, "_unstable"}, unstable_viol, 0);
        checkOutput({pfx, "_overlap"}, overlap_viol, 0);
        checkOutput({pfx, "_stall_we"}, stall_viol, 0);
    endtask

    task automatic verifyReadout(input string pfx);
        checkOutput({pfx, "_nout"}, out_words.size(), 2);
        if (out_words.size() > 0) checkOutput({pfx, "_out0"}, out_words[0], 16'd7);
        if (out_words.size() > 1) checkOutput({pfx, "_out1"}, out_words[1], 16'd8);
    endtask

    task automatic runFullSession(input string pfx, input bit toggle);
        clearMonitor();
        startSession();
        loadFullStream();
        applyStimulus(toggle, 2000);
        waitDone(pfx, 2000);
        checkOutput({pfx, "_quiet_at_done"}, $countones(quiet_outs), 0);
        checkOutput({pfx, "_err"}, err, 0);
        tick();
        checkOutput({pfx, "_done_count"}, done_count, 1);
        checkOutput({pfx, "_start_cycles"}, start_cycles, RC);
        verifyWrites(pfx);
        verifyReadout(pfx);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit          seen;
        int          viol;
        logic [15:0] d0;
        logic [8:0]  a0;

        reset_n   = 1'b0;
        go        = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        run_done  = 1'b0;
        out_ready = 1'b1;
        #3;
        checkOutput("reset_outputs", $countones(quiet_outs) + int'(done) + int'(err), 0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();

        $display("[TB] basic session");
        runFullSession("basic", 1'b0);

        $display("[TB] oversize length");
        clearMonitor();
        startSession();
        stim_q = {16'd600};
        applyStimulus(1'b0, 100);
        waitDone("len_err", 100);
        checkOutput("err_set", err, 1);
        checkOutput("err_busy_low", busy, 0);
        tick();
        checkOutput("err_no_writes", rec_we.size(), 0);
        checkOutput("err_done_count", done_count, 1);
        repeat (3) tick();
        checkOutput("err_sticky", err, 1);
        startSession();
        checkOutput("err_cleared", err, 0);
        repeat (30) tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();

        $display("[TB] stalled stream");
        runFullSession("toggle", 1'b1);

        $display("[TB] early run_done and output backpressure");
        clearMonitor();
        out_ready = 1'b0;
        startSession();
        loadFullStream();
        applyStimulus(1'b0, 2000);
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clock);
            if (start) seen = 1'b1;
        end
        checkOutput("run_start_seen", seen, 1);
        repeat (9) tick();
        run_done = 1'b1;
        tick();
        run_done = 1'b0;
        @(negedge clock);
        checkOutput("gap_start", start, 0);
        checkOutput("gap_start_4", start_4, 0);
        checkOutput("run_done_cycles", start_cycles, 10);
        @(negedge clock);
        checkOutput("readout_begins", start_4, 1);
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clock);
            if (out_valid) seen = 1'b1;
        end
        checkOutput("rout_seen", seen, 1);
        d0   = out_data;
        a0   = addr_ext;
        viol = 0;
        repeat (20) begin
            @(negedge clock);
            if (!out_valid || out_data !== d0 || addr_ext !== a0 || read_en_ext || !start_4) viol++;
        end
        checkOutput("stall_stable", viol, 0);
        checkOutput("stall_data", d0, 16'd7);
        checkOutput("stall_addr", a0, 1);
        tick();
        out_ready = 1'b1;
        waitDone("bp", 200);
        tick();
        checkOutput("bp_done_count", done_count, 1);
        verifyReadout("bp");

        $display("[TB] reset during write pulse");
        clearMonitor();
        startSession();
        stim_q = {16'd3, 16'd10};
        applyStimulus(1'b0, 100);
        #1;
        checkOutput("we_before_reset", iram_write_ext, 2'b01);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("async_reset_outputs", $countones(quiet_outs) + int'(done) + int'(err), 0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        runFullSession("reload", 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ext_load_sequencer.md
Name: ext_load_sequencer

Overview:
- Hardware host-side sequencer directly upstream of top_control_8.
- Consumes a 16-bit word stream (valid/ready) and performs the full session on top_control_8's external port: load each core's IRAM, load DRAM, run the cores, then read back the final-matrix DRAM window.
- Readback words are emitted on a 16-bit output stream.

Parameters:
- NUM_CORES, 8, number of IRAMs; width of iram_write_ext.
- ADDR_W, 9, external address width.
- WR_PULSE, 4, cycles the write enable is held high per word.
- READ_LAT, 5, cycles read_en_ext is held before dram_in is sampled.
- RUN_CYCLES, 120000, maximum cycles start is held high.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- go  in  1  one-cycle pulse that begins a session; ignored while busy.
- in_valid  in  1  input word valid.
- in_ready  out  1  sequencer accepts in_data this cycle.
- in_data  in  16  stream word.
- run_done  in  1  early-termination pulse from the cores during RUN.
- dram_in  in  16  DRAM readback from top_control_8 (dram_in_1).
- out_valid  out  1  readback word valid.
- out_ready  in  1  downstream accepts out_data.
- out_data  out  16  readback word.
- start, start_2, start_3, start_4  out  1 each  run / IRAM-load / DRAM-load / readout mode.
- addr_ext  out  ADDR_W  external address.
- iram_write_ext  out  NUM_CORES  one-hot IRAM write enable; bit k drives iram_write_ext_(k+1).
- dram_write_ext  out  1  DRAM write enable.
- read_en_ext  out  1  DRAM read enable.
- Data_in_ins  out  16  instruction word.
- Data_in_dram  out  16  data word.
- busy  out  1  session in progress.
- done  out  1  pulse at the end of a session.
- err  out  1  sticky length error; cleared by the next go.

Behaviour:
- Reset: every output is 0; core index is 0; state is IDLE.
- Reset mid-session: returns to IDLE immediately with all enables low. The partial load is abandoned.
- Stream format: for core 0..NUM_CORES-1, a length word Lk followed by Lk instructions; then a length word D followed by D data words; then final_start; then final_end.
- Length checks:
  - A length of 0 skips that segment.
  - A length > 2^ADDR_W-1 (511) sets err, pulses done and returns to IDLE.
- in_ready is 1 only in LEN, WSETUP and PARAM states. A word is consumed when in_valid && in_ready.
- addr_ext is loaded with 1 at the start of each segment.
- Per-word write cycle:
  - WSETUP: accept the word, drive Data_in_ins or Data_in_dram.
  - WE: drive iram_write_ext[k] (or dram_write_ext) high for exactly WR_PULSE cycles; data and address are stable.
  - HOLD: one cycle with enables low; addr_ext increments at the end of HOLD.
  - Next word, or next segment.
- Mode strobes:
  - start_2 is high from the first IRAM LEN state through the last IRAM HOLD.
  - One GAP cycle follows with start_2 = start_3 = 0.
  - start_3 is high throughout the DRAM segment.
  - start_2 and start_3 are never high simultaneously.
- PARAM: two words latched into fs and fe. One GAP cycle follows with all mode strobes low.
- RUN:
  - start is high for RUN_CYCLES cycles, or until run_done, whichever is first.
  - run_done in the first RUN cycle still gives at least 1 cycle of start.
  - Then one GAP cycle with start low.
- Readout, with addr_ext = fs:
  - While addr_ext < fe: RSETUP (start_4 = 1, 1 cycle).
  - RWAIT: read_en_ext high for READ_LAT cycles; dram_in is captured into out_data on the last RWAIT cycle.
  - ROUT: read_en_ext low, out_valid high, held with stable out_data until out_ready; addr_ext increments on handshake.
  - fe <= fs produces zero readout words.
  - start_4 stays high for the entire readout phase.
- Readout addressing: fs and fe are truncated to ADDR_W bits. Compare is unsigned. addr_ext increments to at most fe, so no wrap.
- End of session: done pulses 1 cycle; busy falls the same cycle; all outputs return to their reset values except err.
- Backpressure: in_valid low stalls in LEN/WSETUP/PARAM with enables low and addr_ext held. out_ready low stalls in ROUT indefinitely.
- Simultaneous events: go during busy is ignored. A go coinciding with the done cycle is ignored.

Test Plan:
- NUM_CORES=2, L0=3 {10,20,30}, L1=0, D=2 {7,8}, fs=1, fe=3, cores mirror data -> iram_write_ext=01 pulses at addr 1,2,3 with data 10,20,30, each 4 cycles wide. No write to core 1. dram_write_ext pulses at addr 1,2. Outputs 7 then 8. done pulses once.
- Length word 600 for core 0 -> err=1, done pulse, no write enables ever asserted.
- in_valid toggled every other cycle during IRAM load -> identical write sequence, only stretched in time. No enable high while stalled.
- run_done asserted 10 cycles into RUN -> start high for exactly 10 cycles, then readout begins after 1 gap cycle.
- out_ready held low for 20 cycles in ROUT -> out_valid and out_data stable, addr_ext unchanged, read_en_ext low.
- reset_n low during a WE pulse -> all outputs 0 asynchronously. A new go reloads correctly from addr 1.
